// File: rtl/dec.sv
// RV32I decode stage: one instruction per handshake into a single output register.
// Latency 1 cycle; input_ready_o bypasses exm ready, so a held output still accepts when exm drains.
module dec (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [4:0]  rdt1_addr_o,
    input  logic [31:0] rdt1_data_i,
    output logic [4:0]  rdt2_addr_o,
    input  logic [31:0] rdt2_data_i,
    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] alu_operand1_o,
    output logic [31:0] alu_operand2_o,
    output logic [2:0]  alu_op_o,
    output logic        alu_sub_o,
    output logic        alu_shift_left_o,
    output logic        alu_signed_shift_o,
    output logic [2:0]  branch_cond_o,
    output logic [19:0] branch_offset_o,
    output logic        result_write_o,
    output logic [4:0]  result_addr_o,
    output logic        illegal_o
);
    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  op;
        logic        sub;
        logic        sl;
        logic        ss;
        logic [2:0]  cond;
        logic [19:0] off;
        logic        wr;
        logic [4:0]  rd;
    } fields_t;

    fields_t     fields_q, fields_d, dec_f;
    logic        valid_q, valid_d;
    logic        ill_q, ill_d;
    logic        dec_ill;
    logic        xfer;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign rd  = instr_i[11:7];

    assign rdt1_addr_o   = instr_i[19:15];
    assign rdt2_addr_o   = instr_i[24:20];
    assign input_ready_o = rst_i && (!valid_q || output_ready_i);
    assign xfer          = input_valid_i && input_ready_o && !flush_i;

    always_comb begin
        dec_f   = '0;
        dec_ill = 1'b0;
        case (opc)
            7'b0110111: begin
                dec_f.op2 = {instr_i[31:12], 12'b0};
                dec_f.wr  = (rd != 5'd0);
            end
            7'b0010111: begin
                dec_f.op1 = pc_i;
                dec_f.op2 = {instr_i[31:12], 12'b0};
                dec_f.wr  = (rd != 5'd0);
            end
            7'b1101111: begin
                dec_f.op1  = pc_i;
                dec_f.op2  = 32'd4;
                dec_f.cond = 3'b111;
                dec_f.off  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]};
                dec_f.wr   = (rd != 5'd0);
            end
            7'b1100011: begin
                dec_f.op1 = rdt1_data_i;
                dec_f.op2 = rdt2_data_i;
                dec_f.off = {{8{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8]};
                case (f3)
                    3'b000: begin dec_f.cond = 3'b001; dec_f.sub = 1'b1; end
                    3'b001: begin dec_f.cond = 3'b010; dec_f.sub = 1'b1; end
                    3'b100: begin dec_f.cond = 3'b011; dec_f.op = 3'b010; end
                    3'b101: begin dec_f.cond = 3'b100; dec_f.op = 3'b010; end
                    3'b110: begin dec_f.cond = 3'b101; dec_f.op = 3'b011; end
                    3'b111: begin dec_f.cond = 3'b110; dec_f.op = 3'b011; end
                    default: begin dec_f = '0; dec_ill = 1'b1; end
                endcase
            end
            7'b0010011: begin
                dec_f.op1 = rdt1_data_i;
                dec_f.op  = f3;
                dec_f.wr  = (rd != 5'd0);
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec_f.op2 = {27'b0, instr_i[24:20]};
                    dec_f.ss  = (f3 == 3'b101) && instr_i[30];
                end else begin
                    dec_f.op2 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            7'b0110011: begin
                dec_f.op1 = rdt1_data_i;
                dec_f.op2 = rdt2_data_i;
                dec_f.op  = f3;
                dec_f.sub = (f3 == 3'b000) && instr_i[30];
                dec_f.ss  = (f3 == 3'b101) && instr_i[30];
                dec_f.wr  = (rd != 5'd0);
            end
            default: dec_ill = 1'b1;
        endcase
        dec_f.sl = (dec_f.op == 3'b001);
        // Destination is reported for every decode, bubbles included.
        dec_f.rd = rd;
    end

    // Flush beats transfer beats hold; illegal is a pulse, never held.
    always_comb begin
        valid_d  = valid_q;
        fields_d = fields_q;
        ill_d    = 1'b0;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d  = 1'b1;
            fields_d = dec_f;
            ill_d    = dec_ill;
        end else if (output_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q  <= 1'b0;
            ill_q    <= 1'b0;
            fields_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ill_q    <= ill_d;
            fields_q <= fields_d;
        end
    end

    assign output_valid_o     = valid_q;
    assign illegal_o          = ill_q;
    assign alu_operand1_o     = fields_q.op1;
    assign alu_operand2_o     = fields_q.op2;
    assign alu_op_o           = fields_q.op;
    assign alu_sub_o          = fields_q.sub;
    assign alu_shift_left_o   = fields_q.sl;
    assign alu_signed_shift_o = fields_q.ss;
    assign branch_cond_o      = fields_q.cond;
    assign branch_offset_o    = fields_q.off;
    assign result_write_o     = fields_q.wr;
    assign result_addr_o      = fields_q.rd;
endmodule

// File: tb/tb_dec.sv
// Randomised bench for dec against a mnemonic-level decode model.
module tb_dec;
    logic        clk;
    logic        rst, vld, fl, ordy;
    logic [31:0] ins, pc, d1, d2;
    logic        input_ready_o, output_valid_o, illegal_o;
    logic [4:0]  rdt1_addr_o, rdt2_addr_o, result_addr_o;
    logic [31:0] alu_operand1_o, alu_operand2_o;
    logic [2:0]  alu_op_o, branch_cond_o;
    logic        alu_sub_o, alu_shift_left_o, alu_signed_shift_o, result_write_o;
    logic [19:0] branch_offset_o;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  op;
        logic        sub;
        logic        sl;
        logic        ss;
        logic [2:0]  cond;
        logic [19:0] off;
        logic        wr;
        logic [4:0]  rd;
    } exp_t;

    exp_t e_f, nxt_f;
    logic e_vld, e_ill, e_rdy, nxt_ill;
    int   n_chk, n_bad;

    dec u_dec (
        .clk_i(clk), .rst_i(rst), .input_valid_i(vld), .input_ready_o(input_ready_o),
        .instr_i(ins), .pc_i(pc), .flush_i(fl),
        .rdt1_addr_o(rdt1_addr_o), .rdt1_data_i(d1),
        .rdt2_addr_o(rdt2_addr_o), .rdt2_data_i(d2),
        .output_ready_i(ordy), .output_valid_o(output_valid_o),
        .alu_operand1_o(alu_operand1_o), .alu_operand2_o(alu_operand2_o),
        .alu_op_o(alu_op_o), .alu_sub_o(alu_sub_o),
        .alu_shift_left_o(alu_shift_left_o), .alu_signed_shift_o(alu_signed_shift_o),
        .branch_cond_o(branch_cond_o), .branch_offset_o(branch_offset_o),
        .result_write_o(result_write_o), .result_addr_o(result_addr_o),
        .illegal_o(illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Decode from instruction semantics: byte immediates, then halved for the offset.
    function automatic void model(input logic [31:0] w, input logic [31:0] p,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output exp_t f, output logic ill);
        int   iimm, bimm, jimm;
        logic [31:0] uimm;
        logic [2:0]  f3;
        logic [4:0]  rd;
        f    = '0;
        ill  = 1'b0;
        f3   = w[14:12];
        rd   = w[11:7];
        uimm = w & 32'hFFFF_F000;
        iimm = $signed(w) >>> 20;
        bimm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        jimm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        f.rd = rd;
        case (w[6:0])
            7'h37: begin f.op2 = uimm; f.wr = rd != 0; end
            7'h17: begin f.op1 = p; f.op2 = uimm; f.wr = rd != 0; end
            7'h6F: begin
                f.op1 = p; f.op2 = 4; f.cond = 3'd7; f.off = 20'(jimm / 2); f.wr = rd != 0;
            end
            7'h63: begin
                f.op1 = a; f.op2 = b; f.off = 20'(bimm / 2);
                case (f3)
                    3'd0: begin f.cond = 1; f.sub = 1; end
                    3'd1: begin f.cond = 2; f.sub = 1; end
                    3'd4: begin f.cond = 3; f.op = 2; end
                    3'd5: begin f.cond = 4; f.op = 2; end
                    3'd6: begin f.cond = 5; f.op = 3; end
                    3'd7: begin f.cond = 6; f.op = 3; end
                    default: begin f = '0; f.rd = rd; ill = 1; end
                endcase
            end
            7'h13: begin
                f.op1 = a; f.op = f3; f.wr = rd != 0;
                if (f3 == 1 || f3 == 5) begin
                    f.op2 = 32'(w[24:20]);
                    f.ss  = (f3 == 5) && w[30];
                end else begin
                    f.op2 = 32'(iimm);
                end
                f.sl = (f3 == 1);
            end
            7'h33: begin
                f.op1 = a; f.op2 = b; f.op = f3; f.wr = rd != 0;
                f.sub = (f3 == 0) && w[30];
                f.ss  = (f3 == 5) && w[30];
                f.sl  = (f3 == 1);
            end
            default: ill = 1;
        endcase
    endfunction

    task automatic step(input logic r, input logic v, input logic [31:0] w,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic f);
        rst = r; vld = v; ins = w; pc = p; d1 = a; d2 = b; ordy = o; fl = f;
        #1;
        e_rdy = r && (!e_vld || o);
        chk("in_rdy", 128'(input_ready_o), 128'(e_rdy));
        chk("rs1_addr", 128'(rdt1_addr_o), 128'(w[19:15]));
        chk("rs2_addr", 128'(rdt2_addr_o), 128'(w[24:20]));
        model(w, p, a, b, nxt_f, nxt_ill);
        @(posedge clk);
        if (!r) begin
            e_vld = 0; e_ill = 0; e_f = '0;
        end else if (f) begin
            e_vld = 0; e_ill = 0;
        end else if (v && e_rdy) begin
            e_vld = 1; e_ill = nxt_ill; e_f = nxt_f;
        end else begin
            e_ill = 0;
            if (o) e_vld = 0;
        end
        #1;
        chk("out_vld", 128'(output_valid_o), 128'(e_vld));
        chk("illegal", 128'(illegal_o), 128'(e_ill));
        chk("fields", 128'({alu_operand1_o, alu_operand2_o, alu_op_o, alu_sub_o,
                            alu_shift_left_o, alu_signed_shift_o, branch_cond_o,
                            branch_offset_o, result_write_o, result_addr_o}), 128'(e_f));
    endtask

    logic [6:0] opcs [7];
    logic [31:0] w;

    initial begin
        n_chk = 0; n_bad = 0;
        e_vld = 0; e_ill = 0; e_f = '0;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h13, 7'h33, 7'h00};

        step(0, 1, 32'hFFB10093, 32'h100, 10, 0, 1, 0);
        step(0, 1, 32'hFFB10093, 32'h100, 10, 0, 1, 0);
        chk("rst_vld", 128'(output_valid_o), 128'(0));
        chk("rst_op1", 128'(alu_operand1_o), 128'(0));

        step(1, 1, 32'hFFB10093, 32'h100, 10, 0, 1, 0);
        chk("addi_op1", 128'(alu_operand1_o), 128'(10));
        chk("addi_op2", 128'(alu_operand2_o), 128'(32'hFFFFFFFB));
        chk("addi_wr", 128'({result_write_o, result_addr_o}), 128'({1'b1, 5'd1}));

        step(1, 1, 32'h405201B3, 32'h104, 7, 9, 1, 0);
        chk("sub_sub", 128'({alu_op_o, alu_sub_o, result_addr_o}), 128'({3'b000, 1'b1, 5'd3}));

        step(1, 1, 32'hFE208CE3, 32'h108, 5, 5, 1, 0);
        chk("beq_off", 128'({branch_cond_o, branch_offset_o, result_write_o}),
            128'({3'b001, 20'hFFFFC, 1'b0}));

        for (int i = 0; i < 3; i++) step(1, 1, 32'h00500113, 32'h10C, 1, 2, 0, 0);
        chk("bp_hold", 128'(branch_offset_o), 128'(20'hFFFFC));
        step(1, 1, 32'h00500113, 32'h10C, 1, 2, 1, 0);
        chk("bp_take", 128'(alu_operand2_o), 128'(5));

        step(1, 1, 32'h00300193, 32'h110, 0, 0, 1, 1);
        chk("flush_vld", 128'(output_valid_o), 128'(0));
        step(1, 1, 32'h00000000, 32'h114, 0, 0, 1, 0);
        chk("ill_pulse", 128'({output_valid_o, illegal_o, result_write_o}), 128'(3'b110));
        step(1, 0, 32'h00000000, 32'h118, 0, 0, 1, 0);
        chk("ill_clear", 128'(illegal_o), 128'(0));

        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 6)];
            if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, w,
                 $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
